serializador_bits: RTL and testbench

- Parallel-to-serial stage directly upstream of the sequence detectors.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit at a time on serial output m, which drives the detectors' m input.
- Each bit is held for DIV clock cycles.
- Back-to-back words stream with no gap, so patterns spanning a word boundary remain detectable.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/divisor_bit.sv | 40 ++++
 rtl/serializador_bits.sv | 79 +++++++
 tb/tb_serializador_bits.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit serializer feeding the sequence detectors.
package serial_pkg;

    // Serializer state encoding.
    typedef enum logic {
        IDLE     = 1'b0,
        DESPLAZA = 1'b1
    } estado_t;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DIV_DEF   = 1;

    // Divider counter width; never narrower than one bit, even for DIV=1.
    function automatic int unsigned ancho_div(input int unsigned div);
        if (div > 1) begin
            return $clog2(div);
        end
        return 1;
    endfunction

endpackage

// File: rtl/divisor_bit.sv
// Bit-period divider: counts enabled cycles 0..DIV-1 and strobes tick on the last one.
module divisor_bit
    import serial_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   DW   = ancho_div(DIV);
    localparam logic [DW-1:0] TERM = DW'(DIV - 1);

    logic [DW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == TERM);

    // Next count: clear on a new word, wrap at the terminal value, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serializador_bits.sv
// Parallel-to-serial stage: accepts a word over valido/listo and shifts it out on m.
module serializador_bits
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned DIV       = DIV_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dato,
    input  logic             valido,
    output logic             listo,
    output logic             m,
    output logic             m_tick,
    output logic             ocupado,
    output logic             fin
);

    localparam int unsigned BW = $clog2(WIDTH);

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic             tick;
    logic             ultimo;
    logic             acepta;

    divisor_bit #(
        .DIV (DIV)
    ) u_divisor (
        .clk  (clk),
        .rst  (rst),
        .en   (estado_q == DESPLAZA),
        .clr  (acepta),
        .tick (tick)
    );

    // Last cycle of the word's last bit; a new word may be taken here without a gap.
    assign ultimo  = (estado_q == DESPLAZA) && tick && (bitcnt_q == '0);
    assign listo   = (estado_q == IDLE) || ultimo;
    assign acepta  = valido && listo;

    assign ocupado = (estado_q == DESPLAZA);
    assign m_tick  = tick;
    assign fin     = ultimo;
    assign m       = (estado_q == DESPLAZA) && (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);

    // Next state: load on accept, drop to IDLE after the last bit, shift at each bit end.
    always_comb begin
        estado_d = estado_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        if (acepta) begin
            estado_d = DESPLAZA;
            sr_d     = dato;
            bitcnt_d = BW'(WIDTH - 1);
        end else if (ultimo) begin
            estado_d = IDLE;
        end else if (tick) begin
            sr_d     = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
            bitcnt_d = bitcnt_q - 1'b1;
        end
    end

    // State, shift register and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q <= IDLE;
            sr_q     <= '0;
            bitcnt_q <= '0;
        end else begin
            estado_q <= estado_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
        end
    end

endmodule

// File: tb/tb_serializador_bits.sv
// Scoreboard bench for serializador_bits: three instances cover DIV=1/MSB, DIV=3, LSB-first.
module tb_serializador_bits;

    typedef struct packed {
        logic b;
        logic ultimo;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] dato_a, dato_b, dato_c;
    logic       valido_a, valido_b, valido_c;
    logic       listo_a, listo_b, listo_c;
    logic       m_a, m_b, m_c;
    logic       tick_a, tick_b, tick_c;
    logic       ocu_a, ocu_b, ocu_c;
    logic       fin_a, fin_b, fin_c;

    logic [2:0] m_v, tick_v, ocu_v, fin_v;
    int         div_v [3] = '{1, 3, 1};
    int         per [3]   = '{0, 0, 0};
    exp_t       sb_q [3][$];

    int n_vec = 0;
    int n_err = 0;

    assign m_v    = {m_c, m_b, m_a};
    assign tick_v = {tick_c, tick_b, tick_a};
    assign ocu_v  = {ocu_c, ocu_b, ocu_a};
    assign fin_v  = {fin_c, fin_b, fin_a};

    serializador_bits #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .dato(dato_a), .valido(valido_a), .listo(listo_a),
        .m(m_a), .m_tick(tick_a), .ocupado(ocu_a), .fin(fin_a)
    );

    serializador_bits #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .dato(dato_b), .valido(valido_b), .listo(listo_b),
        .m(m_b), .m_tick(tick_b), .ocupado(ocu_b), .fin(fin_b)
    );

    serializador_bits #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst(rst), .dato(dato_c), .valido(valido_c), .listo(listo_c),
        .m(m_c), .m_tick(tick_c), .ocupado(ocu_c), .fin(fin_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nom, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nom, act, exp, $time);
        end
    endtask

    // Queue the expected serial bits of one word in transmission order.
    task automatic push(input int d, input logic [7:0] w, input bit msb);
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = msb ? 7 - i : i;
            sb_q[d].push_back('{b: w[idx], ultimo: (i == 7)});
        end
    endtask

    // Monitor: every busy cycle must show the queued bit; the bit retires on m_tick.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ocu_v[d]) begin
                if (sb_q[d].size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mon%0d_extra: got busy output m=%0b, expected no word", d, m_v[d]);
                end else begin
                    exp_t h;
                    h = sb_q[d][0];
                    chk($sformatf("mon%0d_m", d), 32'(m_v[d]), 32'(h.b));
                    chk($sformatf("mon%0d_fin", d), 32'(fin_v[d]), 32'(h.ultimo && tick_v[d]));
                    per[d]++;
                    if (tick_v[d]) begin
                        chk($sformatf("mon%0d_periodo", d), 32'(per[d]), 32'(div_v[d]));
                        per[d] = 0;
                        void'(sb_q[d].pop_front());
                    end
                end
            end else begin
                per[d] = 0;
                chk($sformatf("mon%0d_m_idle", d), 32'(m_v[d]), 32'd0);
                chk($sformatf("mon%0d_fin_idle", d), 32'(fin_v[d] | tick_v[d]), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b0;
        valido_a = 1'b0; valido_b = 1'b0; valido_c = 1'b0;
        dato_a = '0; dato_b = '0; dato_c = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_listo", 32'({listo_c, listo_b, listo_a}), 32'h7);
        chk("rst_m", 32'(m_v), 32'h0);
        chk("rst_ocupado", 32'(ocu_v), 32'h0);
        chk("rst_fin_tick", 32'({fin_v, tick_v}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single word A5, MSB first, DIV=1
        valido_a = 1'b1; dato_a = 8'hA5; push(0, 8'hA5, 1'b1);
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                chk($sformatf("a5_listo_c%0d", c), 32'(listo_a), 32'(c == 0 || c == 8));
                chk($sformatf("a5_ocupado_c%0d", c), 32'(ocu_a), 32'(c >= 1));
            end else begin
                chk("a5_fin_estado", 32'({m_a, listo_a, ocu_a}), 32'b010);
            end
            @(posedge clk); #1;
            if (c == 0) begin valido_a = 1'b0; dato_a = '0; end
        end

        // Back-to-back A5 then 5A with valido held high
        for (int c = 0; c <= 17; c++) begin
            if (c == 0) begin valido_a = 1'b1; dato_a = 8'hA5; push(0, 8'hA5, 1'b1); end
            if (c == 8) begin dato_a = 8'h5A; push(0, 8'h5A, 1'b1); end
            if (c == 9) begin valido_a = 1'b0; dato_a = '0; end
            @(negedge clk);
            chk($sformatf("b2b_listo_c%0d", c), 32'(listo_a),
                32'(c == 0 || c == 8 || c == 16 || c == 17));
            chk($sformatf("b2b_ocupado_c%0d", c), 32'(ocu_a), 32'(c >= 1 && c <= 16));
            @(posedge clk); #1;
        end

        // valido with FF during cycles 2..7 of word 3C is ignored
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) begin valido_a = 1'b1; dato_a = 8'h3C; push(0, 8'h3C, 1'b1); end
            if (c == 1) begin valido_a = 1'b0; dato_a = '0; end
            if (c == 2) begin valido_a = 1'b1; dato_a = 8'hFF; end
            if (c == 8) begin valido_a = 1'b0; dato_a = '0; end
            @(negedge clk);
            if (c >= 2 && c <= 7) chk($sformatf("ign_listo_c%0d", c), 32'(listo_a), 32'd0);
            if (c == 9) chk("ign_ocupado_fin", 32'(ocu_a), 32'd0);
            @(posedge clk); #1;
        end

        // Reset mid-word during bit 4 of F0, then word 81
        for (int c = 0; c <= 4; c++) begin
            if (c == 0) begin valido_a = 1'b1; dato_a = 8'hF0; push(0, 8'hF0, 1'b1); end
            if (c == 1) begin valido_a = 1'b0; dato_a = '0; end
            @(negedge clk);
            if (c == 4) begin
                chk("rstmid_m_antes", 32'(m_a), 32'd1);
                #2 rst = 1'b0;
                #1;
                chk("rstmid_m_ocu_fin", 32'({m_a, ocu_a, fin_a}), 32'b000);
                chk("rstmid_listo", 32'(listo_a), 32'd1);
                sb_q[0].delete();
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) begin valido_a = 1'b1; dato_a = 8'h81; push(0, 8'h81, 1'b1); end
            if (c == 1) begin valido_a = 1'b0; dato_a = '0; end
            @(negedge clk);
            if (c == 0) chk("post_rst_listo", 32'(listo_a), 32'd1);
            if (c == 1) chk("post_rst_m_c1", 32'({m_a, ocu_a}), 32'b11);
            if (c == 9) chk("post_rst_ocupado", 32'(ocu_a), 32'd0);
            @(posedge clk); #1;
        end

        // DIV=3, word C3
        for (int c = 0; c <= 25; c++) begin
            if (c == 0) begin valido_b = 1'b1; dato_b = 8'hC3; push(1, 8'hC3, 1'b1); end
            if (c == 1) begin valido_b = 1'b0; dato_b = '0; end
            @(negedge clk);
            if (c == 0) chk("div3_listo", 32'(listo_b), 32'd1);
            if (c >= 1 && c <= 24) begin
                chk($sformatf("div3_tick_c%0d", c), 32'(tick_b), 32'(c % 3 == 0));
                chk($sformatf("div3_fin_c%0d", c), 32'(fin_b), 32'(c == 24));
            end
            if (c == 25) chk("div3_ocupado_fin", 32'(ocu_b), 32'd0);
            @(posedge clk); #1;
        end

        // LSB first, word 01
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) begin valido_c = 1'b1; dato_c = 8'h01; push(2, 8'h01, 1'b0); end
            if (c == 1) begin valido_c = 1'b0; dato_c = '0; end
            @(negedge clk);
            if (c >= 1 && c <= 8) chk($sformatf("lsb_m_c%0d", c), 32'(m_c), 32'(c == 1));
            if (c == 9) chk("lsb_ocupado_fin", 32'(ocu_c), 32'd0);
            @(posedge clk); #1;
        end

        // Every queued bit must have been observed
        for (int k = 0; k < 50; k++) begin
            if (sb_q[0].size() == 0 && sb_q[1].size() == 0 && sb_q[2].size() == 0) break;
            @(posedge clk);
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("sb%0d_pendientes", d), 32'(sb_q[d].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
